// File: rtl/fp_max_seq_pkg.sv
// -----------------------------------------------------------------------------
// fp_max_seq_pkg
// Shared definitions for the running-maximum sequencer:
//   - 13-bit floating-point operand layout (sign, 4-bit exponent, 8-bit fraction)
//   - FSM state encoding used by fp_max_seq
// -----------------------------------------------------------------------------
package fp_max_seq_pkg;

    localparam int FP_EXP_W  = 4;
    localparam int FP_FRAC_W = 8;
    localparam int FP_W      = 1 + FP_EXP_W + FP_FRAC_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FIRST = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic                 sign;
        logic [FP_EXP_W-1:0]  exp;
        logic [FP_FRAC_W-1:0] frac;
    } fp_t;

endpackage

// File: rtl/fp_max_seq_fp_gtr.sv
// -----------------------------------------------------------------------------
// fp_gtr
// Combinational strict greater-than for sign-magnitude 13-bit floats.
//   iSign1/iExp1/iFrac1 : operand 1
//   iSign2/iExp2/iFrac2 : operand 2
//   oGtr                : 1 when operand 1 > operand 2 (equal values give 0)
// A positive operand always beats a negative one; with equal signs the
// {exp,frac} magnitudes are compared, reversed for negative values.
// -----------------------------------------------------------------------------
module fp_gtr
    import fp_max_seq_pkg::*;
(
    input  logic                 iSign1,
    input  logic [FP_EXP_W-1:0]  iExp1,
    input  logic [FP_FRAC_W-1:0] iFrac1,
    input  logic                 iSign2,
    input  logic [FP_EXP_W-1:0]  iExp2,
    input  logic [FP_FRAC_W-1:0] iFrac2,
    output logic                 oGtr
);

    logic [FP_EXP_W+FP_FRAC_W-1:0] mag1;
    logic [FP_EXP_W+FP_FRAC_W-1:0] mag2;

    assign mag1 = {iExp1, iFrac1};
    assign mag2 = {iExp2, iFrac2};

    always_comb begin
        oGtr = 1'b0;
        if (iSign1 != iSign2) begin
            oGtr = ~iSign1;
        end else if (iSign1) begin
            oGtr = (mag1 < mag2);
        end else begin
            oGtr = (mag1 > mag2);
        end
    end

endmodule

// File: rtl/fp_max_seq.sv
// -----------------------------------------------------------------------------
// fp_max_seq
// Streams a burst of floats through one shared fp_gtr and reports the maximum
// and the index of its first occurrence.
//   iClk, iReset        : clock, synchronous active-high reset
//   iStart, iLen        : start a burst of iLen operands (sampled in IDLE)
//   iValid / oReady     : operand handshake; iSign/iExp/iFrac carry the operand
//   oBusy               : high from FIRST through DONE
//   oDone               : one-cycle result pulse
//   oEmpty              : burst had zero operands
//   oSign/oExp/oFrac    : maximum value, oIdx its 0-based position
// Results hold after DONE until the next accepted iStart or reset.
// -----------------------------------------------------------------------------
module fp_max_seq
    import fp_max_seq_pkg::*;
#(
    parameter int MAX_LEN = 16,
    parameter int CNT_W   = 5
)(
    input  logic                 iClk,
    input  logic                 iReset,
    input  logic                 iStart,
    input  logic [CNT_W-1:0]     iLen,
    input  logic                 iValid,
    output logic                 oReady,
    input  logic                 iSign,
    input  logic [FP_EXP_W-1:0]  iExp,
    input  logic [FP_FRAC_W-1:0] iFrac,
    output logic                 oBusy,
    output logic                 oDone,
    output logic                 oEmpty,
    output logic                 oSign,
    output logic [FP_EXP_W-1:0]  oExp,
    output logic [FP_FRAC_W-1:0] oFrac,
    output logic [CNT_W-1:0]     oIdx
);

    localparam logic [CNT_W-1:0] MAX_LEN_C = CNT_W'(MAX_LEN);
    localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [CNT_W-1:0] pos_q, pos_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    fp_t              max_q, max_d;
    logic             empty_q, empty_d;
    logic             ready_q, busy_q, done_q;

    fp_t  op_in;
    logic gtr;
    logic hs;

    assign op_in = '{sign: iSign, exp: iExp, frac: iFrac};
    // ready_q is high exactly in FIRST/RUN, so this is the accepted handshake
    assign hs    = iValid & ready_q;

    fp_gtr u_gtr (
        .iSign1 (op_in.sign),
        .iExp1  (op_in.exp),
        .iFrac1 (op_in.frac),
        .iSign2 (max_q.sign),
        .iExp2  (max_q.exp),
        .iFrac2 (max_q.frac),
        .oGtr   (gtr)
    );

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        pos_d   = pos_q;
        idx_d   = idx_q;
        max_d   = max_q;
        empty_d = empty_q;
        case (state_q)
            IDLE: begin
                if (iStart) begin
                    empty_d = 1'b0;
                    pos_d   = '0;
                    if (iLen == '0) begin
                        empty_d = 1'b1;
                        max_d   = '0;
                        idx_d   = '0;
                        state_d = DONE;
                    end else begin
                        rem_d   = (iLen > MAX_LEN_C) ? MAX_LEN_C : iLen;
                        state_d = FIRST;
                    end
                end
            end
            FIRST: begin
                if (hs) begin
                    max_d   = op_in;
                    idx_d   = '0;
                    pos_d   = ONE_C;
                    rem_d   = rem_q - ONE_C;
                    state_d = (rem_q == ONE_C) ? DONE : RUN;
                end
            end
            RUN: begin
                if (hs) begin
                    // strict compare: ties keep the earlier operand
                    if (gtr) begin
                        max_d = op_in;
                        idx_d = pos_q;
                    end
                    pos_d = pos_q + ONE_C;
                    rem_d = rem_q - ONE_C;
                    if (rem_q == ONE_C) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Handshake/status flags are registered from the next state so they
    // line up with the state they describe.
    always_ff @(posedge iClk) begin
        if (iReset) begin
            state_q <= IDLE;
            rem_q   <= '0;
            pos_q   <= '0;
            idx_q   <= '0;
            max_q   <= '0;
            empty_q <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            pos_q   <= pos_d;
            idx_q   <= idx_d;
            max_q   <= max_d;
            empty_q <= empty_d;
            ready_q <= (state_d == FIRST) || (state_d == RUN);
            busy_q  <= (state_d != IDLE);
            done_q  <= (state_d == DONE);
        end
    end

    assign oReady = ready_q;
    assign oBusy  = busy_q;
    assign oDone  = done_q;
    assign oEmpty = empty_q;
    assign oSign  = max_q.sign;
    assign oExp   = max_q.exp;
    assign oFrac  = max_q.frac;
    assign oIdx   = idx_q;

endmodule

// File: tb/tb_fp_max_seq.sv
// -----------------------------------------------------------------------------
// tb_fp_max_seq
// Scoreboard bench for fp_max_seq: each burst pushes its expected result when
// the stimulus is driven; the result captured on oDone is popped and compared.
// -----------------------------------------------------------------------------
module tb_fp_max_seq;

    logic       clk = 1'b0;
    logic       iReset;
    logic       iStart;
    logic [4:0] iLen;
    logic       iValid;
    logic       oReady;
    logic       iSign;
    logic [3:0] iExp;
    logic [7:0] iFrac;
    logic       oBusy;
    logic       oDone;
    logic       oEmpty;
    logic       oSign;
    logic [3:0] oExp;
    logic [7:0] oFrac;
    logic [4:0] oIdx;

    always #5 clk = ~clk;

    fp_max_seq #(.MAX_LEN(16), .CNT_W(5)) dut (
        .iClk   (clk),
        .iReset (iReset),
        .iStart (iStart),
        .iLen   (iLen),
        .iValid (iValid),
        .oReady (oReady),
        .iSign  (iSign),
        .iExp   (iExp),
        .iFrac  (iFrac),
        .oBusy  (oBusy),
        .oDone  (oDone),
        .oEmpty (oEmpty),
        .oSign  (oSign),
        .oExp   (oExp),
        .oFrac  (oFrac),
        .oIdx   (oIdx)
    );

    typedef struct packed {
        logic       s;
        logic [3:0] e;
        logic [7:0] f;
        logic [4:0] idx;
        logic       empty;
        logic       rdy;
    } res_t;

    res_t exp_q[$];
    res_t got_q[$];

    int cyc       = 0;
    int hs_total  = 0;
    int done_cyc  = 0;
    int start_cyc = 0;
    int n_total   = 0;
    int n_bad     = 0;

    logic       op_s [32];
    logic [3:0] op_e [32];
    logic [7:0] op_f [32];

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: handshakes are counted on the negedge before the edge that
    // takes them; results are captured while oDone is high.
    always @(negedge clk) begin
        if (!iReset && iValid && oReady) hs_total <= hs_total + 1;
        if (oDone) begin
            got_q.push_back('{s: oSign, e: oExp, f: oFrac, idx: oIdx,
                              empty: oEmpty, rdy: oReady});
            done_cyc <= cyc;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_total++;
        if (got !== expv) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, expv);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic push_exp(input logic s, input logic [3:0] e, input logic [7:0] f,
                            input logic [4:0] idx, input logic empty);
        exp_q.push_back('{s: s, e: e, f: f, idx: idx, empty: empty, rdy: 1'b0});
    endtask

    task automatic start_burst(input logic [4:0] len);
        @(posedge clk); #1;
        iStart = 1'b1;
        iLen   = len;
        @(posedge clk); #1;
        start_cyc = cyc;
        iStart = 1'b0;
    endtask

    task automatic feed_op(input int i, input bit stall, input bit poke);
        int t;
        if (stall) begin
            iValid = 1'b0;
            @(posedge clk); #1;
        end
        iSign  = op_s[i];
        iExp   = op_e[i];
        iFrac  = op_f[i];
        iValid = 1'b1;
        if (poke) begin
            iStart = 1'b1;
            iLen   = 5'd5;
        end
        t = 0;
        while (!oReady && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 50) check_val("ready_timeout", 32'(oReady), 32'd1);
        @(posedge clk); #1;
        iStart = 1'b0;
    endtask

    task automatic finish_burst(input string name, input int hs0, input int exp_hs,
                                input bit chk_lat, input int lat, input int extra);
        int   t;
        res_t g, x;
        repeat (extra) begin
            @(posedge clk); #1;
        end
        iValid = 1'b0;
        t = 0;
        while (got_q.size() == 0 && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        check_val({name, "_done_seen"}, 32'(got_q.size() > 0), 32'd1);
        if (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            x = exp_q.pop_front();
            check_val({name, "_max"}, 32'({g.s, g.e, g.f}), 32'({x.s, x.e, x.f}));
            check_val({name, "_idx"}, 32'(g.idx), 32'(x.idx));
            check_val({name, "_empty"}, 32'(g.empty), 32'(x.empty));
            check_val({name, "_rdy_in_done"}, 32'(g.rdy), 32'(x.rdy));
        end
        check_val({name, "_handshakes"}, 32'(hs_total - hs0), 32'(exp_hs));
        if (chk_lat) check_val({name, "_latency"}, 32'(done_cyc - start_cyc), 32'(lat));
        @(posedge clk); #1;
        check_val({name, "_busy_after"}, 32'(oBusy), 32'd0);
    endtask

    task automatic set_op(input int i, input logic s, input logic [3:0] e, input logic [7:0] f);
        op_s[i] = s;
        op_e[i] = e;
        op_f[i] = f;
    endtask

    initial begin
        int hs0;
        int n;
        int best_key;
        int best_idx;
        int key;

        iReset = 1'b1;
        iStart = 1'b0;
        iLen   = '0;
        iValid = 1'b0;
        iSign  = 1'b0;
        iExp   = '0;
        iFrac  = '0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_flags", 32'({oReady, oBusy, oDone, oEmpty}), 32'd0);
        check_val("rst_result", 32'({oSign, oExp, oFrac, oIdx}), 32'd0);
        iReset = 1'b0;

        // iValid while IDLE: no operand consumed
        @(posedge clk); #1;
        iValid = 1'b1;
        hs0 = hs_total;
        repeat (2) @(posedge clk);
        #1;
        check_val("idle_ready", 32'(oReady), 32'd0);
        check_val("idle_no_hs", 32'(hs_total - hs0), 32'd0);
        iValid = 1'b0;

        // increasing burst, iValid kept high into DONE/IDLE afterwards
        set_op(0, 1'b0, 4'd3, 8'h10);
        set_op(1, 1'b0, 4'd5, 8'h20);
        set_op(2, 1'b0, 4'd5, 8'h80);
        set_op(3, 1'b0, 4'd7, 8'h01);
        push_exp(1'b0, 4'd7, 8'h01, 5'd3, 1'b0);
        hs0 = hs_total;
        start_burst(5'd4);
        check_val("busy_rise", 32'(oBusy), 32'd1);
        for (int i = 0; i < 4; i++) feed_op(i, 1'b0, 1'b0);
        finish_burst("incr", hs0, 4, 1'b1, 4, 3);

        // ties and negatives, plus an iStart pulse mid-RUN
        set_op(0, 1'b1, 4'd4, 8'h40);
        set_op(1, 1'b1, 4'd2, 8'h00);
        set_op(2, 1'b1, 4'd2, 8'h00);
        push_exp(1'b1, 4'd2, 8'h00, 5'd1, 1'b0);
        hs0 = hs_total;
        start_burst(5'd3);
        for (int i = 0; i < 3; i++) feed_op(i, 1'b0, i == 1);
        finish_burst("ties", hs0, 3, 1'b1, 3, 0);
        check_val("ties_no_restart", 32'(got_q.size() + exp_q.size()), 32'd0);

        // mixed signs with a bubble before every operand
        set_op(0, 1'b1, 4'd9, 8'hFF);
        set_op(1, 1'b0, 4'd1, 8'h01);
        set_op(2, 1'b1, 4'd0, 8'h00);
        push_exp(1'b0, 4'd1, 8'h01, 5'd1, 1'b0);
        hs0 = hs_total;
        start_burst(5'd3);
        for (int i = 0; i < 3; i++) feed_op(i, 1'b1, 1'b0);
        finish_burst("stall", hs0, 3, 1'b1, 6, 0);

        // zero length
        push_exp(1'b0, 4'd0, 8'h00, 5'd0, 1'b1);
        hs0 = hs_total;
        start_burst(5'd0);
        finish_burst("zero", hs0, 0, 1'b1, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        check_val("empty_hold", 32'(oEmpty), 32'd1);

        // clamp: iLen=31 takes exactly 16 operands; extra iValid is ignored
        for (int i = 0; i < 16; i++) set_op(i, 1'b0, 4'(i), 8'h00);
        push_exp(1'b0, 4'd15, 8'h00, 5'd15, 1'b0);
        hs0 = hs_total;
        start_burst(5'd31);
        check_val("empty_clear", 32'(oEmpty), 32'd0);
        for (int i = 0; i < 16; i++) feed_op(i, 1'b0, 1'b0);
        finish_burst("clamp", hs0, 16, 1'b1, 16, 3);

        // random nonzero operands, checked against a signed-magnitude key model
        n = 7;
        best_key = 0;
        best_idx = 0;
        for (int i = 0; i < n; i++) begin
            set_op(i, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                   8'($urandom_range(1, 255)));
            key = op_s[i] ? -int'({op_e[i], op_f[i]}) : int'({op_e[i], op_f[i]});
            if (i == 0 || key > best_key) begin
                best_key = key;
                best_idx = i;
            end
        end
        push_exp(op_s[best_idx], op_e[best_idx], op_f[best_idx], 5'(best_idx), 1'b0);
        hs0 = hs_total;
        start_burst(5'(n));
        for (int i = 0; i < n; i++) feed_op(i, 1'($urandom_range(0, 1)), 1'b0);
        finish_burst("rand", hs0, n, 1'b0, 0, 0);

        // reset after 2 of 4 handshakes
        for (int i = 0; i < 4; i++) set_op(i, 1'b0, 4'd9, 8'h33);
        start_burst(5'd4);
        feed_op(0, 1'b0, 1'b0);
        feed_op(1, 1'b0, 1'b0);
        iValid = 1'b0;
        iReset = 1'b1;
        @(posedge clk); #1;
        iReset = 1'b0;
        check_val("mid_rst_flags", 32'({oReady, oBusy, oDone, oEmpty}), 32'd0);
        check_val("mid_rst_result", 32'({oSign, oExp, oFrac, oIdx}), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check_val("mid_rst_no_done", 32'(got_q.size()), 32'd0);

        set_op(0, 1'b0, 4'd1, 8'h02);
        push_exp(1'b0, 4'd1, 8'h02, 5'd0, 1'b0);
        hs0 = hs_total;
        start_burst(5'd1);
        feed_op(0, 1'b0, 1'b0);
        finish_burst("after_rst", hs0, 1, 1'b1, 1, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
